prf_read_arbiter: RTL and testbench

Arbitrates the physical register file's read requesters onto its banked read ports. Each of the `PRF_RR_COUNT` requesters presents a physical register tag. Each of the `PRF_BANK_COUNT` banks serves one read per cycle, and a per-bank round-robin pointer keeps the arbitration fair. The block sits between the issue-queue operand read logic and the PRF bank arrays: grants go back to requesters combinationally, and bank read commands are registered toward the arrays.

---
 rtl/prf_read_arbiter.sv | 173 +++++++++++++++++
 tb/tb_prf_read_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_read_arbiter.sv
// ---------------------------------------------------------------------------
// prf_read_arbiter
//
// Arbitrates PRF read requesters onto banked read ports. Each bank keeps its
// own round-robin pointer and picks at most one winner per cycle. Grants return
// to the requesters combinationally. The winning read command goes out
// registered toward the bank arrays.
//
// Ports
//   CLK                         clock, rising edge
//   nRST                        asynchronous active-low reset
//   req_valid_by_rr             request valid, one bit per requester
//   req_pr_by_rr                requested physical register, per requester
//   bank_ready_by_bank          bank read port available this cycle
//   req_ack_by_rr               combinational grant, per requester
//   bank_read_valid_by_bank     registered read command valid, per bank
//   bank_read_upper_pr_by_bank  registered in-bank row index, per bank
//   bank_read_rr_by_bank        registered winner requester index, per bank
// ---------------------------------------------------------------------------

// Per-bank slice: candidate filter, round-robin scan, pointer and command regs.
module prf_read_arbiter_bank #(
   parameter int unsigned RR_CNT   = 11,
   parameter int unsigned PR_W     = 7,
   parameter int unsigned BANK_W   = 2,
   parameter int unsigned BANK_IDX = 0,
   parameter int unsigned RR_W     = 4,
   parameter int unsigned ROW_W    = 5
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic [RR_CNT-1:0]           req_valid_i,
   input  logic [RR_CNT-1:0][PR_W-1:0] req_pr_i,
   input  logic                        bank_ready_i,
   output logic [RR_CNT-1:0]           ack_o,
   output logic                        rd_valid_o,
   output logic [ROW_W-1:0]            rd_row_o,
   output logic [RR_W-1:0]             rd_rr_o
);

   logic [RR_CNT-1:0] cand;
   logic              found;
   logic [RR_W-1:0]   win;
   logic [RR_W:0]     idx;
   logic              grant;

   logic [RR_W-1:0]   ptr_q, ptr_d;
   logic              rd_valid_q;
   logic [ROW_W-1:0]  rd_row_q;
   logic [RR_W-1:0]   rd_rr_q;

   // A requester is a candidate here only if its tag's low bits select this bank.
   always_comb begin
      cand = '0;
      for (int r = 0; r < int'(RR_CNT); r++) begin
         cand[r] = req_valid_i[r] &&
                   (req_pr_i[r][BANK_W-1:0] == BANK_W'(BANK_IDX));
      end
   end

   // Scan from the pointer upward, wrapping at RR_CNT. The sum fits in
   // RR_W+1 bits because both operands are below RR_CNT <= 2**RR_W.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < int'(RR_CNT); i++) begin
         idx = {1'b0, ptr_q} + (RR_W+1)'(i);
         if (idx >= (RR_W+1)'(RR_CNT)) begin
            idx = idx - (RR_W+1)'(RR_CNT);
         end
         if (!found && cand[idx[RR_W-1:0]]) begin
            found = 1'b1;
            win   = idx[RR_W-1:0];
         end
      end
   end

   assign grant = found & bank_ready_i;

   always_comb begin
      ack_o = '0;
      if (grant) begin
         ack_o[win] = 1'b1;
      end
   end

   // The pointer moves just past the winner so that winner has lowest priority
   // next time. It holds when there is no grant, so a stalled bank keeps
   // its order.
   always_comb begin
      ptr_d = ptr_q;
      if (grant) begin
         ptr_d = (win == RR_W'(RR_CNT - 1)) ? '0 : win + RR_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ptr_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_row_q   <= '0;
         rd_rr_q    <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rd_valid_q <= grant;
         // Row/index hold when idle. They are don't-care while valid is low.
         if (grant) begin
            rd_row_q <= req_pr_i[win][PR_W-1:BANK_W];
            rd_rr_q  <= win;
         end
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_row_o   = rd_row_q;
   assign rd_rr_o    = rd_rr_q;

endmodule

module prf_read_arbiter #(
   parameter int unsigned PRF_RR_COUNT   = 11,
   parameter int unsigned PRF_BANK_COUNT = 4,
   parameter int unsigned PR_COUNT       = 128,
   localparam int unsigned LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
   localparam int unsigned LOG_PR_COUNT       = $clog2(PR_COUNT),
   localparam int unsigned ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT,
   localparam int unsigned RR_W               = (PRF_RR_COUNT > 1) ? $clog2(PRF_RR_COUNT) : 1
) (
   input  logic                                      CLK,
   input  logic                                      nRST,
   input  logic [PRF_RR_COUNT-1:0]                   req_valid_by_rr,
   input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0] req_pr_by_rr,
   input  logic [PRF_BANK_COUNT-1:0]                 bank_ready_by_bank,
   output logic [PRF_RR_COUNT-1:0]                   req_ack_by_rr,
   output logic [PRF_BANK_COUNT-1:0]                 bank_read_valid_by_bank,
   output logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]      bank_read_upper_pr_by_bank,
   output logic [PRF_BANK_COUNT-1:0][RR_W-1:0]       bank_read_rr_by_bank
);

   logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] ack_by_bank;

   for (genvar b = 0; b < int'(PRF_BANK_COUNT); b++) begin : g_bank
      prf_read_arbiter_bank #(
         .RR_CNT   (PRF_RR_COUNT),
         .PR_W     (LOG_PR_COUNT),
         .BANK_W   (LOG_PRF_BANK_COUNT),
         .BANK_IDX (b),
         .RR_W     (RR_W),
         .ROW_W    (ROW_W)
      ) u_bank (
         .CLK          (CLK),
         .nRST         (nRST),
         .req_valid_i  (req_valid_by_rr),
         .req_pr_i     (req_pr_by_rr),
         .bank_ready_i (bank_ready_by_bank[b]),
         .ack_o        (ack_by_bank[b]),
         .rd_valid_o   (bank_read_valid_by_bank[b]),
         .rd_row_o     (bank_read_upper_pr_by_bank[b]),
         .rd_rr_o      (bank_read_rr_by_bank[b])
      );
   end

   // A requester maps to exactly one bank, so OR-ing the per-bank grants
   // never merges two different winners for the same requester.
   always_comb begin
      req_ack_by_rr = '0;
      for (int b = 0; b < int'(PRF_BANK_COUNT); b++) begin
         req_ack_by_rr = req_ack_by_rr | ack_by_bank[b];
      end
   end

endmodule

// File: tb/tb_prf_read_arbiter.sv
module tb_prf_read_arbiter;

   localparam int RR = 11;
   localparam int NB = 4;
   localparam int PRW = 7;
   localparam int ROWW = 5;
   localparam int RRW = 4;

   logic                      CLK = 1'b0;
   logic                      nRST;
   logic [RR-1:0]             req_valid;
   logic [RR-1:0][PRW-1:0]    req_pr;
   logic [NB-1:0]             bank_ready;
   logic [RR-1:0]             ack;
   logic [NB-1:0]             rd_valid;
   logic [NB-1:0][ROWW-1:0]   rd_row;
   logic [NB-1:0][RRW-1:0]    rd_rr;

   int n_tests = 0;
   int n_fail  = 0;

   prf_read_arbiter dut (
      .CLK                        (CLK),
      .nRST                       (nRST),
      .req_valid_by_rr            (req_valid),
      .req_pr_by_rr               (req_pr),
      .bank_ready_by_bank         (bank_ready),
      .req_ack_by_rr              (ack),
      .bank_read_valid_by_bank    (rd_valid),
      .bank_read_upper_pr_by_bank (rd_row),
      .bank_read_rr_by_bank       (rd_rr)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr();
      req_valid  = '0;
      req_pr     = '0;
      bank_ready = '1;
   endtask

   task automatic do_reset();
      clr();
      nRST = 1'b0;
      tick();
      tick();
      nRST = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clr();
      nRST = 1'b0;
      for (int r = 0; r < RR; r++) begin
         req_valid[r] = 1'b1;
         req_pr[r]    = PRW'(r);
      end
      tick();
      tick();
      n_tests++;
      if (rd_valid !== 4'h0) begin n_fail++; $display("FAIL rst_valid got %h exp 0", rd_valid); end
      n_tests++;
      if (rd_row !== '0) begin n_fail++; $display("FAIL rst_row got %h exp 0", rd_row); end
      n_tests++;
      if (rd_rr !== '0) begin n_fail++; $display("FAIL rst_rr got %h exp 0", rd_rr); end
      n_tests++;
      if (ack !== 11'h00f) begin n_fail++; $display("FAIL rst_ack got %h exp 00f", ack); end
      nRST = 1'b1;
      tick();
      n_tests++;
      if (rd_valid !== 4'hf) begin n_fail++; $display("FAIL rel_valid got %h exp f", rd_valid); end
      n_tests++;
      if (rd_rr !== {4'd3, 4'd2, 4'd1, 4'd0}) begin n_fail++; $display("FAIL rel_rr got %h exp 3210", rd_rr); end
      n_tests++;
      if (rd_row !== '0) begin n_fail++; $display("FAIL rel_row got %h exp 0", rd_row); end
      // pointers now 1,2,3,4 -> winners 4,5,6,7
      n_tests++;
      if (ack !== 11'h0f0) begin n_fail++; $display("FAIL rel_ack2 got %h exp 0f0", ack); end
      tick();
      n_tests++;
      if (rd_rr !== {4'd7, 4'd6, 4'd5, 4'd4}) begin n_fail++; $display("FAIL rel_rr2 got %h exp 7654", rd_rr); end
      n_tests++;
      if (rd_row !== {5'd1, 5'd1, 5'd1, 5'd1}) begin n_fail++; $display("FAIL rel_row2 got %h exp all 1", rd_row); end
   endtask

   task automatic test_bank_parallel();
      do_reset();
      for (int r = 0; r < 4; r++) begin
         req_valid[r] = 1'b1;
         req_pr[r]    = PRW'(4 + r);
      end
      #1;
      n_tests++;
      if (ack !== 11'h00f) begin n_fail++; $display("FAIL par_ack got %h exp 00f", ack); end
      tick();
      clr();
      n_tests++;
      if (rd_valid !== 4'hf) begin n_fail++; $display("FAIL par_valid got %h exp f", rd_valid); end
      n_tests++;
      if (rd_row !== {5'd1, 5'd1, 5'd1, 5'd1}) begin n_fail++; $display("FAIL par_row got %h exp all 1", rd_row); end
      n_tests++;
      if (rd_rr !== {4'd3, 4'd2, 4'd1, 4'd0}) begin n_fail++; $display("FAIL par_rr got %h exp 3210", rd_rr); end
      #1;
      tick();
      n_tests++;
      if (rd_valid !== 4'h0) begin n_fail++; $display("FAIL par_idle got %h exp 0", rd_valid); end
   endtask

   // Leaves rr_ptr[1] at 10 for test_wrap.
   task automatic test_conflict();
      do_reset();
      req_valid[2] = 1'b1; req_pr[2] = 7'h01;
      req_valid[5] = 1'b1; req_pr[5] = 7'h11;
      req_valid[9] = 1'b1; req_pr[9] = 7'h21;
      #1;
      n_tests++;
      if (ack !== 11'h004) begin n_fail++; $display("FAIL cf_ack0 got %h exp 004", ack); end
      tick();
      req_valid[2] = 1'b0;
      n_tests++;
      if (rd_valid !== 4'b0010 || rd_rr[1] !== 4'd2 || rd_row[1] !== 5'd0) begin
         n_fail++; $display("FAIL cf_cmd0 got v=%b rr=%0d row=%0d exp v=0010 rr=2 row=0", rd_valid, rd_rr[1], rd_row[1]);
      end
      #1;
      n_tests++;
      if (ack !== 11'h020) begin n_fail++; $display("FAIL cf_ack1 got %h exp 020", ack); end
      tick();
      req_valid[5] = 1'b0;
      n_tests++;
      if (rd_valid !== 4'b0010 || rd_rr[1] !== 4'd5 || rd_row[1] !== 5'd4) begin
         n_fail++; $display("FAIL cf_cmd1 got v=%b rr=%0d row=%0d exp v=0010 rr=5 row=4", rd_valid, rd_rr[1], rd_row[1]);
      end
      #1;
      n_tests++;
      if (ack !== 11'h200) begin n_fail++; $display("FAIL cf_ack2 got %h exp 200", ack); end
      tick();
      req_valid[9] = 1'b0;
      n_tests++;
      if (rd_valid !== 4'b0010 || rd_rr[1] !== 4'd9 || rd_row[1] !== 5'd8) begin
         n_fail++; $display("FAIL cf_cmd2 got v=%b rr=%0d row=%0d exp v=0010 rr=9 row=8", rd_valid, rd_rr[1], rd_row[1]);
      end
   endtask

   task automatic test_wrap();
      clr();
      req_valid[10] = 1'b1; req_pr[10] = 7'h05;
      req_valid[0]  = 1'b1; req_pr[0]  = 7'h09;
      #1;
      n_tests++;
      if (ack !== 11'h400) begin n_fail++; $display("FAIL wrap_ack0 got %h exp 400", ack); end
      tick();
      n_tests++;
      if (rd_valid[1] !== 1'b1 || rd_rr[1] !== 4'd10 || rd_row[1] !== 5'd1) begin
         n_fail++; $display("FAIL wrap_cmd0 got v=%b rr=%0d row=%0d exp v=1 rr=10 row=1", rd_valid[1], rd_rr[1], rd_row[1]);
      end
      // rr10 re-requests; pointer wrapped to 0 so rr0 must win
      #1;
      n_tests++;
      if (ack !== 11'h001) begin n_fail++; $display("FAIL wrap_ack1 got %h exp 001", ack); end
      tick();
      clr();
      n_tests++;
      if (rd_valid[1] !== 1'b1 || rd_rr[1] !== 4'd0 || rd_row[1] !== 5'd2) begin
         n_fail++; $display("FAIL wrap_cmd1 got v=%b rr=%0d row=%0d exp v=1 rr=0 row=2", rd_valid[1], rd_rr[1], rd_row[1]);
      end
   endtask

   task automatic test_not_ready();
      do_reset();
      bank_ready = 4'b0111;
      req_valid[4] = 1'b1; req_pr[4] = 7'h0B;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_tests++;
         if (ack !== 11'h000) begin n_fail++; $display("FAIL nr_ack%0d got %h exp 000", k, ack); end
         tick();
         n_tests++;
         if (rd_valid[3] !== 1'b0) begin n_fail++; $display("FAIL nr_valid%0d got %b exp 0", k, rd_valid[3]); end
      end
      bank_ready = 4'b1111;
      #1;
      n_tests++;
      if (ack !== 11'h010) begin n_fail++; $display("FAIL nr_ack_rdy got %h exp 010", ack); end
      tick();
      n_tests++;
      if (rd_valid !== 4'b1000 || rd_rr[3] !== 4'd4 || rd_row[3] !== 5'd2) begin
         n_fail++; $display("FAIL nr_cmd got v=%b rr=%0d row=%0d exp v=1000 rr=4 row=2", rd_valid, rd_rr[3], rd_row[3]);
      end
      // pointer now 5: rr9 beats rr4
      req_valid[9] = 1'b1; req_pr[9] = 7'h0F;
      #1;
      n_tests++;
      if (ack !== 11'h200) begin n_fail++; $display("FAIL nr_ptr_ack got %h exp 200", ack); end
      tick();
      clr();
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int r = 0; r < 4; r++) begin
         req_valid[r] = 1'b1;
         req_pr[r]    = PRW'(4 + r);
      end
      tick();
      clr();
      n_tests++;
      if (rd_valid !== 4'hf) begin n_fail++; $display("FAIL mr_pre got %h exp f", rd_valid); end
      #2;
      nRST = 1'b0;
      #1;
      n_tests++;
      if (rd_valid !== 4'h0) begin n_fail++; $display("FAIL mr_valid got %h exp 0", rd_valid); end
      n_tests++;
      if (rd_rr !== '0 || rd_row !== '0) begin n_fail++; $display("FAIL mr_regs got rr=%h row=%h exp 0", rd_rr, rd_row); end
      #1;
      nRST = 1'b1;
      req_valid[0] = 1'b1; req_pr[0] = 7'h00;
      req_valid[4] = 1'b1; req_pr[4] = 7'h04;
      #1;
      n_tests++;
      if (ack !== 11'h001) begin n_fail++; $display("FAIL mr_ptr_ack got %h exp 001", ack); end
      tick();
      clr();
      n_tests++;
      if (rd_valid !== 4'b0001 || rd_rr[0] !== 4'd0) begin
         n_fail++; $display("FAIL mr_cmd got v=%b rr=%0d exp v=0001 rr=0", rd_valid, rd_rr[0]);
      end
   endtask

   initial begin
      clr();
      nRST = 1'b0;
      test_reset();
      test_bank_parallel();
      test_conflict();
      test_wrap();
      test_not_ready();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
